cache_fill_fsm: RTL
===================

# cache_fill_fsm

Miss-handling controller shared by the I-cache (in FETCH) and the D-cache (in MEMORY). It sits between a cache's tag/data arrays and the arbitrated `memory4c` port. On a miss it reads the 16-byte block (8 words) from main memory. It steers each returned word into the data array, then writes the tag and releases the pipeline stall. It drives the `fsm_busy`/`mem_address` pair that the top-level arbiter consumes, and it consumes that arbiter's enable together with the shared `memory_data_valid`.

## Interface
Parameters:
- `WORDS`, 8, words per cache block; must be a power of two; sizes the counters.
- `ADDR_W`, 16, byte-address width.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `miss_detected`  in  1  cache lookup missed this cycle; only sampled in IDLE.
- `miss_address`  in  ADDR_W  byte address of the missing access; only sampled in IDLE.
- `mem_grant`  in  1  arbiter enable for this cache (`I_cache_enable`/`D_cache_enable`).
- `memory_data`  in  16  read data from `memory4c`.
- `memory_data_valid`  in  1  shared valid from `memory4c`.
- `fsm_busy`  out  1  fill in progress; doubles as the request to the arbiter.
- `mem_read_en`  out  1  a read is issued to memory this cycle.
- `mem_address`  out  ADDR_W  address of the read being issued.
- `write_data_array`  out  1  write `fill_data` into word `data_word_sel` of the block.
- `data_word_sel`  out  log2(WORDS)  word index within the block for the data write.
- `fill_data`  out  16  equals `memory_data` (pass-through).
- `write_tag_array`  out  1  one-cycle pulse to write the tag and valid bit for the block; marks fill complete.

## Operation
- States: IDLE, FILL.
- Registers:
  - `base` (ADDR_W-4 bits), the block address.
  - `issue_cnt` (0..WORDS, log2(WORDS)+1 bits).
  - `recv_cnt` (0..WORDS, same width).
- IDLE:
  - On `miss_detected`, latch `base` = `miss_address[ADDR_W-1:4]`.
  - Clear both counters and go to FILL.
  - Otherwise hold.
- FILL:
  - `fsm_busy` = 1.
  - Issue: `mem_read_en` = `mem_grant` & (`issue_cnt` < WORDS).
    - `mem_address` = {`base`, `issue_cnt[2:0]`, 1'b0}.
    - `issue_cnt` increments on each issue.
    - Outside FILL, and once all reads are issued, `mem_address` = {`base`, 4'b0000}.
  - Accept: a word is accepted when `memory_data_valid` & (`recv_cnt` < `issue_cnt`).
    - Valids with no outstanding read (`recv_cnt` == `issue_cnt`) belong to the other cache and are ignored.
  - Data write: on accept, `write_data_array` = 1, `data_word_sel` = `recv_cnt[2:0]`, and `recv_cnt` increments.
  - Completion: on the accept where `recv_cnt` == WORDS-1, also pulse `write_tag_array` and go to IDLE.
  - While in FILL, `miss_detected` and `miss_address` are ignored.
- Grant loss: if `mem_grant` drops mid-fill, issuing pauses and `issue_cnt` holds. Outstanding returns are still accepted, and issuing resumes at the held index when the grant returns.
- All counter arithmetic is unsigned. Counters never exceed WORDS and never wrap.

## Timing
- Reset (async, immediate): state = IDLE, counters = 0, `base` = 0. All outputs 0 except `fill_data`, which follows `memory_data`.
  - Reset mid-fill abandons the fill with no tag write. Partially written data words are harmless because the tag stays invalid.
- State and counters are registered. All outputs are combinational from state, counters, and the current inputs.
- `fsm_busy` rises the cycle after `miss_detected` is sampled in IDLE. The cache must stall on `miss_detected | fsm_busy`.
- The fill makes no assumption about memory latency; completion is counted, not timed.
- Reference latency: `mem_grant` held high and `memory4c` valid 4 cycles after issue. Counting the miss-accept edge as cycle 0:
  - issues occur in cycles 1-8;
  - valids arrive in cycles 5-12;
  - `write_tag_array` pulses in cycle 12;
  - `fsm_busy` is low from cycle 13.
- Back-to-back misses: a `miss_detected` in the cycle after `write_tag_array` starts a new fill. A miss in the same cycle as the tag pulse is not accepted.

## Test plan
- Reset then idle: hold `rst_n`=0, then release with no miss → all outputs 0 and `mem_address` = 0 for 20 cycles.
- Full fill, 4-cycle memory, grant always high, miss at 0x1236:
  - `mem_address` steps 0x1230, 0x1232, …, 0x123E in cycles 1-8;
  - `data_word_sel` 0-7 in cycles 5-12, with `fill_data` matching the model;
  - `write_tag_array` high only in cycle 12; `fsm_busy` low in cycle 13.
- Grant drop: deassert `mem_grant` for 5 cycles after the 3rd issue:
  - exactly 3 words (0x1230, 0x1232, 0x1234) are accepted;
  - issue resumes at 0x1236;
  - exactly 8 data writes and one tag pulse occur overall.
- Foreign valid: pulse `memory_data_valid` in IDLE, and in FILL with zero outstanding reads → no `write_data_array`, `recv_cnt` unchanged.
- Reset mid-fill: assert `rst_n`=0 after 4 received words → same cycle `fsm_busy`=0 and no tag pulse. A new miss at 0x0040 then fills from 0x0040 with `data_word_sel` starting at 0.
- Back-to-back misses: second miss asserted during FILL and in the tag-pulse cycle is ignored. The same miss held one cycle longer starts a new fill the cycle after the tag pulse.

Source files
------------

// File: rtl/cache_fill_fsm_if.sv
// Handshake bundle between a cache's miss-handling controller and its
// surroundings: miss request from the lookup, arbitrated memory port,
// and the data/tag array write strobes.
interface cache_fill_fsm_if #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
);
  localparam int IDX_W = $clog2(WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              mem_grant;
  logic [15:0]       memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  data_word_sel;
  logic [15:0]       fill_data;
  logic              write_tag_array;

  // Fill controller side.
  modport master (
    input  miss_detected, miss_address, mem_grant, memory_data, memory_data_valid,
    output fsm_busy, mem_read_en, mem_address, write_data_array, data_word_sel,
           fill_data, write_tag_array
  );

  // Cache / arbiter / memory side.
  modport slave (
    output miss_detected, miss_address, mem_grant, memory_data, memory_data_valid,
    input  fsm_busy, mem_read_en, mem_address, write_data_array, data_word_sel,
           fill_data, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: reads one block word-by-word through the
// arbitrated memory port, steers returned words into the data array and
// writes the tag once the last word lands.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no fill; waiting for a miss from the cache lookup
// ST_FILL | issuing reads (while granted) and accepting returned words
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  cache_fill_fsm_if.master bus
);
  localparam int IDX_W  = $clog2(WORDS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int BASE_W = ADDR_W - IDX_W - 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  typedef enum logic {ST_IDLE, ST_FILL} state_t;

  state_t            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;

  logic in_fill;
  logic issue;
  logic accept;
  logic done;

  // Word offset bits of the miss address are implied by the block fill.
  logic unused_miss_offset;
  assign unused_miss_offset = ^bus.miss_address[IDX_W:0];

  // A valid only belongs to us while we have a read outstanding; anything
  // else is the other cache's return on the shared valid line.
  assign in_fill = (state_q == ST_FILL);
  assign issue   = in_fill & bus.mem_grant & (issue_cnt_q < CNT_FULL);
  assign accept  = in_fill & bus.memory_data_valid & (recv_cnt_q < issue_cnt_q);
  assign done    = accept & (recv_cnt_q == CNT_LAST);

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.miss_detected) begin
          base_d      = bus.miss_address[ADDR_W-1:IDX_W+1];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (issue)  issue_cnt_d = issue_cnt_q + 1'b1;
        if (accept) recv_cnt_d  = recv_cnt_q + 1'b1;
        if (done)   state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, block address and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Outputs decoded from current state, counters and inputs; the address
  // parks on the block base whenever no read index is pending.
  always_comb begin
    bus.fsm_busy         = in_fill;
    bus.mem_read_en      = issue;
    bus.write_data_array = accept;
    bus.data_word_sel    = accept ? recv_cnt_q[IDX_W-1:0] : '0;
    bus.write_tag_array  = done;
    bus.fill_data        = bus.memory_data;
    if (in_fill && (issue_cnt_q < CNT_FULL))
      bus.mem_address = {base_q, issue_cnt_q[IDX_W-1:0], 1'b0};
    else
      bus.mem_address = {base_q, {(IDX_W+1){1'b0}}};
  end

endmodule
